// File: rtl/ts_iic_master.sv
// rtl/ts_iic_master.sv - I2C master for touch-controller register reads and writes
module ts_iic_master #(
  parameter logic [6:0] DEV_ADDR = 7'h5D,
  parameter int         QTR_DIV  = 170
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        iic_en,
  input  logic        iic_we,
  input  logic [15:0] iic_addr,
  input  logic [5:0]  iic_len,
  output logic        iic_rdy,
  output logic        iic_nack,
  output logic        buf_we,
  output logic [5:0]  buf_addr,
  output logic [7:0]  buf_wdata,
  input  logic [7:0]  buf_rdata,
  output logic        scl,
  output logic        sda_o,
  input  logic        sda_i
);

  localparam int QW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_ACK, STOP, DONE
  } state_t;

  // Which byte of the transaction the current TX_BYTE/RX_ACK pair belongs to
  typedef enum logic [2:0] {
    PH_DEVW, PH_AHI, PH_ALO, PH_DEVR, PH_WDATA
  } phase_t;

  state_t        state, state_n;
  phase_t        ph, ph_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [1:0]    qph, qph_n;
  logic [2:0]    bitn, bitn_n;
  logic [5:0]    dcnt, dcnt_n;
  logic [7:0]    sh, sh_n;
  logic          we_l, we_n;
  logic [15:0]   addr_l, addr_n;
  logic [5:0]    len_l, len_n;
  logic          nack_l, nack_n;
  logic          ack_nak, ack_nak_n;
  logic          rdy_n, nacko_n, bwe_n;
  logic [7:0]    bwd_n;
  logic          sda_s1, sda_s2;
  logic          tick, bit_end;
  logic          scl_c, sda_c;

  assign tick     = (qcnt == QW'(QTR_DIV - 1));
  assign buf_addr = dcnt;

  // Two-flop synchroniser for the asynchronous SDA pad level
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
    end
  end

  // State, counters, latched request and registered handshake outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      ph        <= PH_DEVW;
      qcnt      <= '0;
      qph       <= 2'd0;
      bitn      <= 3'd7;
      dcnt      <= 6'd0;
      sh        <= 8'd0;
      we_l      <= 1'b0;
      addr_l    <= 16'd0;
      len_l     <= 6'd0;
      nack_l    <= 1'b0;
      ack_nak   <= 1'b0;
      iic_rdy   <= 1'b0;
      iic_nack  <= 1'b0;
      buf_we    <= 1'b0;
      buf_wdata <= 8'd0;
    end else begin
      state     <= state_n;
      ph        <= ph_n;
      qcnt      <= qcnt_n;
      qph       <= qph_n;
      bitn      <= bitn_n;
      dcnt      <= dcnt_n;
      sh        <= sh_n;
      we_l      <= we_n;
      addr_l    <= addr_n;
      len_l     <= len_n;
      nack_l    <= nack_n;
      ack_nak   <= ack_nak_n;
      iic_rdy   <= rdy_n;
      iic_nack  <= nacko_n;
      buf_we    <= bwe_n;
      buf_wdata <= bwd_n;
    end
  end

  // Next-state logic: quarter timing, bit/byte sequencing and abort on NACK
  always_comb begin
    state_n   = state;
    ph_n      = ph;
    qcnt_n    = qcnt;
    qph_n     = qph;
    bitn_n    = bitn;
    dcnt_n    = dcnt;
    sh_n      = sh;
    we_n      = we_l;
    addr_n    = addr_l;
    len_n     = len_l;
    nack_n    = nack_l;
    ack_nak_n = ack_nak;
    rdy_n     = 1'b0;
    nacko_n   = 1'b0;
    bwe_n     = 1'b0;
    bwd_n     = buf_wdata;
    bit_end   = 1'b0;

    if (state != IDLE && state != DONE) begin
      if (tick) begin
        qcnt_n  = '0;
        qph_n   = qph + 2'd1;
        bit_end = (qph == 2'd3);
      end else begin
        qcnt_n = qcnt + QW'(1);
      end
    end

    case (state)
      IDLE: begin
        qcnt_n = '0;
        qph_n  = 2'd0;
        if (iic_en) begin
          state_n = START;
          we_n    = iic_we;
          addr_n  = iic_addr;
          len_n   = iic_len;
          ph_n    = PH_DEVW;
          sh_n    = {DEV_ADDR, 1'b0};
          bitn_n  = 3'd7;
          dcnt_n  = 6'd0;
          nack_n  = 1'b0;
        end
      end
      START: begin
        if (bit_end) state_n = TX_BYTE;
      end
      TX_BYTE: begin
        if (bit_end) begin
          if (bitn == 3'd0) begin
            state_n = RX_ACK;
            // Advance the buffer index during the ACK bit so the next
            // byte's buf_rdata is settled long before it is loaded.
            if (ph == PH_WDATA) dcnt_n = dcnt + 6'd1;
          end else begin
            bitn_n = bitn - 3'd1;
            sh_n   = {sh[6:0], 1'b0};
          end
        end
      end
      RX_ACK: begin
        if (tick && qph == 2'd1 + 2'd1) ack_nak_n = sda_s2;
        if (bit_end) begin
          bitn_n = 3'd7;
          if (ack_nak) begin
            nack_n  = 1'b1;
            state_n = STOP;
          end else begin
            case (ph)
              PH_DEVW: begin
                ph_n    = PH_AHI;
                sh_n    = addr_l[15:8];
                state_n = TX_BYTE;
              end
              PH_AHI: begin
                ph_n    = PH_ALO;
                sh_n    = addr_l[7:0];
                state_n = TX_BYTE;
              end
              PH_ALO: begin
                if (len_l == 6'd0) begin
                  state_n = STOP;
                end else if (we_l) begin
                  ph_n    = PH_WDATA;
                  sh_n    = buf_rdata;
                  state_n = TX_BYTE;
                end else begin
                  ph_n    = PH_DEVR;
                  state_n = RSTART;
                end
              end
              PH_DEVR: begin
                state_n = RX_BYTE;
              end
              default: begin
                if (dcnt == len_l) begin
                  state_n = STOP;
                end else begin
                  sh_n    = buf_rdata;
                  state_n = TX_BYTE;
                end
              end
            endcase
          end
        end
      end
      RSTART: begin
        if (bit_end) begin
          sh_n    = {DEV_ADDR, 1'b1};
          bitn_n  = 3'd7;
          state_n = TX_BYTE;
        end
      end
      RX_BYTE: begin
        if (tick && qph == 2'd2) begin
          sh_n = {sh[6:0], sda_s2};
          if (bitn == 3'd0) begin
            bwe_n = 1'b1;
            bwd_n = {sh[6:0], sda_s2};
          end
        end
        if (bit_end) begin
          if (bitn == 3'd0) begin
            state_n = TX_ACK;
            dcnt_n  = dcnt + 6'd1;
          end else begin
            bitn_n = bitn - 3'd1;
          end
        end
      end
      TX_ACK: begin
        if (bit_end) begin
          bitn_n  = 3'd7;
          state_n = (dcnt == len_l) ? STOP : RX_BYTE;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = DONE;
          rdy_n   = 1'b1;
          nacko_n = nack_l;
        end
      end
      DONE: begin
        state_n = IDLE;
        qcnt_n  = '0;
        qph_n   = 2'd0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus levels per state and quarter; SCL is low in q0-q1 of every clocked bit
  always_comb begin
    scl_c = 1'b1;
    sda_c = 1'b1;
    case (state)
      START:           sda_c = ~qph[1];
      TX_BYTE: begin
        scl_c = qph[1];
        sda_c = sh[7];
      end
      RX_ACK, RX_BYTE: scl_c = qph[1];
      RSTART: begin
        scl_c = qph[1];
        sda_c = (qph != 2'd3);
      end
      TX_ACK: begin
        scl_c = qph[1];
        sda_c = (dcnt == len_l);
      end
      STOP: begin
        scl_c = qph[1];
        sda_c = (qph == 2'd3);
      end
      default: ;
    endcase
  end

  // Register the pad drives so they never glitch; reset releases the bus at once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl   <= 1'b1;
      sda_o <= 1'b1;
    end else begin
      scl   <= scl_c;
      sda_o <= sda_c;
    end
  end

endmodule

// File: tb/tb_ts_iic_master.sv
// tb/tb_ts_iic_master.sv - directed bench with a behavioural I2C slave
module tb_ts_iic_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        iic_en = 1'b0;
  logic        iic_we = 1'b0;
  logic [15:0] iic_addr = 16'd0;
  logic [5:0]  iic_len = 6'd0;
  logic        iic_rdy, iic_nack, buf_we, scl, sda_o;
  logic [5:0]  buf_addr;
  logic [7:0]  buf_wdata, buf_rdata;
  logic        slv_sda = 1'b1;
  logic        bus_sda;
  logic [7:0]  mem [64];

  assign bus_sda   = sda_o & slv_sda;
  assign buf_rdata = mem[buf_addr];

  ts_iic_master #(.DEV_ADDR(7'h5D), .QTR_DIV(4)) dut (
    .clk(clk), .rstn(rstn), .iic_en(iic_en), .iic_we(iic_we),
    .iic_addr(iic_addr), .iic_len(iic_len), .iic_rdy(iic_rdy),
    .iic_nack(iic_nack), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata), .scl(scl),
    .sda_o(sda_o), .sda_i(bus_sda)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus transcript: 'h100 START, 'h200 STOP, 'h000-'h0FF byte, 'h300|bit ACK slot
  int   log_q[$];
  int   exp_q[$];
  int   bwa_q[$];
  int   bwd_q[$];
  int   rdy_cnt = 0;
  logic last_nack = 1'b0;
  int   nack_at = -1;
  int   rd_base = 0;

  always @(negedge clk) begin
    if (iic_rdy) begin
      rdy_cnt++;
      last_nack = iic_nack;
    end
    if (buf_we) begin
      bwa_q.push_back(int'(buf_addr));
      bwd_q.push_back(int'(buf_wdata));
    end
  end

  int         bcnt = 0, byte_idx = 0, rx_cnt = 0, rd_idx = 0;
  logic [7:0] s_sh = 8'd0, tx_b = 8'd0;
  logic       tx_mode = 1'b0, rd_req = 1'b0, last_ack = 1'b1;
  logic       p_scl = 1'b1, p_sda = 1'b1, c_scl, c_sda;

  // Slave: ACKs addressed bytes, returns rd_base+k on reads, logs the bus
  always @(negedge clk) begin
    if (!rstn) begin
      slv_sda = 1'b1; bcnt = 0; tx_mode = 1'b0; rd_req = 1'b0;
      p_scl = 1'b1; p_sda = 1'b1;
    end else begin
      c_scl = scl;
      c_sda = bus_sda;
      if (p_scl && c_scl && p_sda && !c_sda) begin
        log_q.push_back('h100);
        bcnt = 0; byte_idx = 0; rx_cnt = 0; rd_idx = 0;
        tx_mode = 1'b0; rd_req = 1'b0; slv_sda = 1'b1;
      end else if (p_scl && c_scl && !p_sda && c_sda) begin
        log_q.push_back('h200);
        bcnt = 0; tx_mode = 1'b0; slv_sda = 1'b1;
      end else if (!p_scl && c_scl) begin
        if (bcnt < 8) begin
          s_sh = {s_sh[6:0], c_sda};
          bcnt++;
          if (bcnt == 8) begin
            log_q.push_back(int'(s_sh));
            if (byte_idx == 0 && !tx_mode) rd_req = s_sh[0];
          end
        end else begin
          log_q.push_back('h300 | int'(c_sda));
          last_ack = c_sda;
          bcnt = 9;
        end
      end else if (p_scl && !c_scl) begin
        if (bcnt == 8) begin
          if (!tx_mode) begin
            slv_sda = (rx_cnt == nack_at);
            rx_cnt++;
          end else begin
            slv_sda = 1'b1;
          end
        end else if (bcnt == 9) begin
          bcnt = 0;
          if (!tx_mode && byte_idx == 0 && rd_req && !slv_sda) begin
            tx_mode = 1'b1;
            tx_b = 8'(rd_base + rd_idx);
            slv_sda = tx_b[7];
          end else if (tx_mode && !last_ack) begin
            rd_idx++;
            tx_b = 8'(rd_base + rd_idx);
            slv_sda = tx_b[7];
          end else begin
            tx_mode = 1'b0;
            slv_sda = 1'b1;
          end
          byte_idx++;
        end else if (tx_mode && bcnt >= 1 && bcnt <= 7) begin
          slv_sda = tx_b[7 - bcnt];
        end else if (!tx_mode) begin
          slv_sda = 1'b1;
        end
      end
      p_scl = c_scl;
      p_sda = c_sda;
    end
  end

  task automatic e_byte(input int b, input int ack);
    exp_q.push_back(b);
    exp_q.push_back('h300 | ack);
  endtask

  task automatic chk_log(input string tag, input int base);
    chk({tag, " len"}, log_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i),
          (base + i < log_q.size()) ? log_q[base + i] : -1, exp_q[i]);
  endtask

  task automatic run_txn(input logic we, input logic [15:0] a, input logic [5:0] len,
                         output logic got);
    int t;
    @(posedge clk); #1;
    iic_we = we; iic_addr = a; iic_len = len; iic_en = 1'b1;
    got = 1'b0;
    t = 0;
    while (!got && t < 20000) begin
      @(negedge clk);
      if (iic_rdy) got = 1'b1;
      t++;
    end
    @(posedge clk); #1;
    iic_en = 1'b0; iic_we = 1'b0; iic_addr = 16'd0; iic_len = 6'd0;
    repeat (40) @(posedge clk);
  endtask

  int   lb, bb, rb, t;
  logic got;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    #1 rstn = 1'b0;
    #2;
    chk("rst scl", scl, 1);
    chk("rst sda_o", sda_o, 1);
    chk("rst iic_rdy", iic_rdy, 0);
    chk("rst iic_nack", iic_nack, 0);
    chk("rst buf_we", buf_we, 0);
    chk("rst buf_addr", buf_addr, 0);
    chk("rst buf_wdata", buf_wdata, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) @(posedge clk);

    // Write 8040h, one byte 02h; iic_en held through the iic_rdy cycle
    mem[0] = 8'h02;
    lb = log_q.size(); bb = bwa_q.size(); rb = rdy_cnt;
    run_txn(1'b1, 16'h8040, 6'd1, got);
    chk("wr1 rdy seen", got, 1);
    exp_q.delete();
    exp_q.push_back('h100);
    e_byte('hBA, 0); e_byte('h80, 0); e_byte('h40, 0); e_byte('h02, 0);
    exp_q.push_back('h200);
    chk_log("wr1 bus", lb);
    chk("wr1 rdy count", rdy_cnt - rb, 1);
    chk("wr1 nack", last_nack, 0);
    chk("wr1 buf_we count", bwa_q.size() - bb, 0);
    chk("wr1 idle scl", scl, 1);
    chk("wr1 idle sda", sda_o, 1);

    // Read 814Eh, one byte returned as 80h
    rd_base = 'h80;
    lb = log_q.size(); bb = bwa_q.size(); rb = rdy_cnt;
    run_txn(1'b0, 16'h814E, 6'd1, got);
    chk("rd1 rdy seen", got, 1);
    exp_q.delete();
    exp_q.push_back('h100);
    e_byte('hBA, 0); e_byte('h81, 0); e_byte('h4E, 0);
    exp_q.push_back('h100);
    e_byte('hBB, 0); e_byte('h80, 1);
    exp_q.push_back('h200);
    chk_log("rd1 bus", lb);
    chk("rd1 rdy count", rdy_cnt - rb, 1);
    chk("rd1 nack", last_nack, 0);
    chk("rd1 buf_we count", bwa_q.size() - bb, 1);
    chk("rd1 buf_addr", (bwa_q.size() > bb) ? bwa_q[bb] : -1, 0);
    chk("rd1 buf_wdata", (bwd_q.size() > bb) ? bwd_q[bb] : -1, 'h80);

    // Read 8150h, 40 bytes 00h..27h
    rd_base = 0;
    lb = log_q.size(); bb = bwa_q.size(); rb = rdy_cnt;
    run_txn(1'b0, 16'h8150, 6'd40, got);
    chk("rd40 rdy seen", got, 1);
    exp_q.delete();
    exp_q.push_back('h100);
    e_byte('hBA, 0); e_byte('h81, 0); e_byte('h50, 0);
    exp_q.push_back('h100);
    e_byte('hBB, 0);
    for (int k = 0; k < 40; k++) e_byte(k, (k == 39) ? 1 : 0);
    exp_q.push_back('h200);
    chk_log("rd40 bus", lb);
    chk("rd40 rdy count", rdy_cnt - rb, 1);
    chk("rd40 buf_we count", bwa_q.size() - bb, 40);
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("rd40 addr%0d", k), (bwa_q.size() > bb + k) ? bwa_q[bb + k] : -1, k);
      chk($sformatf("rd40 data%0d", k), (bwd_q.size() > bb + k) ? bwd_q[bb + k] : -1, k);
    end

    // Slave NACKs its device address
    nack_at = 0;
    lb = log_q.size(); bb = bwa_q.size(); rb = rdy_cnt;
    run_txn(1'b0, 16'h1234, 6'd2, got);
    nack_at = -1;
    chk("nak rdy seen", got, 1);
    exp_q.delete();
    exp_q.push_back('h100);
    e_byte('hBA, 1);
    exp_q.push_back('h200);
    chk_log("nak bus", lb);
    chk("nak rdy count", rdy_cnt - rb, 1);
    chk("nak nack", last_nack, 1);
    chk("nak buf_we count", bwa_q.size() - bb, 0);

    // Zero-length read: address phase only
    lb = log_q.size(); bb = bwa_q.size(); rb = rdy_cnt;
    run_txn(1'b0, 16'h00FF, 6'd0, got);
    chk("len0 rdy seen", got, 1);
    exp_q.delete();
    exp_q.push_back('h100);
    e_byte('hBA, 0); e_byte('h00, 0); e_byte('hFF, 0);
    exp_q.push_back('h200);
    chk_log("len0 bus", lb);
    chk("len0 nack", last_nack, 0);
    chk("len0 buf_we count", bwa_q.size() - bb, 0);

    // Reset in the middle of a read
    rd_base = 'h10;
    bb = bwa_q.size(); rb = rdy_cnt;
    @(posedge clk); #1;
    iic_we = 1'b0; iic_addr = 16'h8150; iic_len = 6'd8; iic_en = 1'b1;
    t = 0;
    while (bwa_q.size() == bb && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("rst-mid first byte seen", bwa_q.size() > bb, 1);
    repeat (20) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("rst-mid scl", scl, 1);
    chk("rst-mid sda_o", sda_o, 1);
    chk("rst-mid buf_we", buf_we, 0);
    iic_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (10) @(posedge clk);
    chk("rst-mid no rdy", rdy_cnt - rb, 0);

    // Fresh write after the aborted read
    mem[0] = 8'hA5; mem[1] = 8'h3C;
    lb = log_q.size(); bb = bwa_q.size(); rb = rdy_cnt;
    run_txn(1'b1, 16'h1234, 6'd2, got);
    chk("wr2 rdy seen", got, 1);
    exp_q.delete();
    exp_q.push_back('h100);
    e_byte('hBA, 0); e_byte('h12, 0); e_byte('h34, 0); e_byte('hA5, 0); e_byte('h3C, 0);
    exp_q.push_back('h200);
    chk_log("wr2 bus", lb);
    chk("wr2 rdy count", rdy_cnt - rb, 1);
    chk("wr2 nack", last_nack, 0);
    chk("wr2 buf_we count", bwa_q.size() - bb, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_iic_master.md
TS_IIC_MASTER -- requirements
Module: ts_iic_master

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h5D, 7-bit touch-controller slave address.
REQ-002 SHALL have parameter QTR_DIV, default 170, clk cycles per quarter SCL period (100 kHz at 68 MHz).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port iic_en  input  1  transaction request, held high by the requester until iic_rdy.
REQ-006 SHALL have port iic_we  input  1  1 = register write, 0 = register read; valid while iic_en is high.
REQ-007 SHALL have port iic_addr  input  16  target register address, sent high byte first.
REQ-008 SHALL have port iic_len  input  6  data byte count, 0..63.
REQ-009 SHALL have port iic_rdy  output  1  one-cycle completion pulse.
REQ-010 SHALL have port iic_nack  output  1  high in the iic_rdy cycle if any slave NACK aborted the transaction.
REQ-011 SHALL have port buf_we  output  1  one-cycle byte-buffer write strobe (read data).
REQ-012 SHALL have port buf_addr  output  6  byte-buffer index.
REQ-013 SHALL have port buf_wdata  output  8  received byte.
REQ-014 SHALL have port buf_rdata  input  8  combinational buffer[buf_addr], bytes to transmit.
REQ-015 SHALL have port scl  output  1  1 = release (pulled high), 0 = drive low.
REQ-016 SHALL have port sda_o  output  1  1 = release, 0 = drive low.
REQ-017 SHALL have port sda_i  input  1  SDA pad level, asynchronous.

Function
REQ-018 SHALL synchronise sda_i through two flops before any use.
REQ-019 SHALL generate a quarter tick every QTR_DIV clk cycles while not IDLE; counter held at 0 in IDLE.
REQ-020 SHALL time each bit as 4 quarters: q0-q1 SCL low (SDA updated at q0 start), q2-q3 SCL high, sda sampled at end of q2.
REQ-021 SHALL implement states IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_ACK, STOP, DONE.
REQ-022 SHALL leave IDLE only when iic_en=1, latching iic_we/iic_addr/iic_len in that cycle; inputs ignored outside IDLE.
REQ-023 SHALL build START as SDA falling while SCL high, STOP as SDA rising while SCL high, each one full bit period.
REQ-024 SHALL send for every transaction: START, {DEV_ADDR,0}, addr[15:8], addr[7:0], each followed by RX_ACK.
REQ-025 SHALL, for writes, then send iic_len bytes taken from buf_rdata with buf_addr = 0..len-1, MSB first, then STOP.
REQ-026 SHALL, for reads with len>0, then RSTART, send {DEV_ADDR,1}, receive len bytes MSB first, ACK all but the last, NACK the last, then STOP.
REQ-027 SHALL pulse buf_we one cycle after bit 0 of received byte i is sampled, with buf_addr=i, buf_wdata=byte.
REQ-028 SHALL present buf_addr=i at least one cycle before sampling buf_rdata for transmit byte i.
REQ-029 SHALL, for len=0, send address phase only then STOP (no read phase, no buf_we).
REQ-030 SHALL, on SDA high at any RX_ACK sample, skip remaining bytes, go to STOP, and set iic_nack in DONE.
REQ-031 SHALL in DONE assert iic_rdy (and iic_nack if aborted) for exactly one cycle, then return to IDLE; minimum IDLE dwell one cycle.
REQ-032 SHALL keep scl=1, sda_o=1, buf_we=0 in IDLE; scl never driven high while SDA changes except START/RSTART/STOP.
REQ-033 SHALL complete a transaction in progress even if iic_en drops mid-transaction.

Reset
REQ-034 SHALL on rstn low immediately force state IDLE, scl=1, sda_o=1, iic_rdy=0, iic_nack=0, buf_we=0, buf_addr=0, buf_wdata=0, counters 0.
REQ-035 SHALL on reset mid-transaction release the bus without issuing STOP; next transaction starts with a fresh START.

Verification
REQ-036 Write 8040h len=1 buf[0]=02h, slave ACKs -> SDA bytes BAh,80h,40h,02h, STOP, one iic_rdy, iic_nack=0.
REQ-037 Read 814Eh len=1, slave returns 80h -> BAh,81h,4Eh, RSTART, BBh, master NACK, buf_we with addr 0 data 80h, iic_rdy.
REQ-038 Read 8150h len=40 incrementing data 00h..27h -> 40 buf_we pulses addr 0..39 matching data, 39 ACKs then NACK, one iic_rdy.
REQ-039 Slave NACKs device address -> STOP after first byte, no buf_we, iic_rdy with iic_nack=1.
REQ-040 rstn low mid-read byte -> scl=1, sda_o=1 same cycle, no iic_rdy; subsequent write completes normally.
REQ-041 iic_en held high through iic_rdy cycle -> exactly one transaction per request, IDLE dwell at least one cycle.
